// File: rtl/gpio_ext_clk_driver.sv
// rtl/gpio_ext_clk_driver.sv - GPIO pattern engine with per-bit ext_clk-relative update timing
//
// Purpose: accepts one GPIO pattern per req_valid/req_ready handshake and drives
// each bit either at accept, ahead of the ext_clk rising edge, or ahead of the
// ext_clk falling edge, generating exactly one ext_clk pulse per transaction.
//
// Ports:
//   clk, rst_n            clock (posedge) and synchronous active-low reset
//   req_valid/req_ready   pattern handshake (req_ready is combinational)
//   req_data              target gpio value
//   req_use_ext           per bit: 1 = update relative to ext_clk, 0 = update at accept
//   req_edge              per bit: 1 = before ext_clk rise, 0 = before ext_clk fall
//   abort                 cancel the transaction in flight
//   gpio, ext_clk         registered pin outputs
//   busy, done, txn_cnt   status: engine active, completion pulse, completed count
module gpio_ext_clk_driver #(
   parameter int                WIDTH     = 32,
   parameter int                SETUP_CYC = 2,
   parameter int                HIGH_CYC  = 5,
   parameter int                LOW_CYC   = 5,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [WIDTH-1:0]  req_data,
   input  logic [WIDTH-1:0]  req_use_ext,
   input  logic [WIDTH-1:0]  req_edge,
   input  logic              abort,
   output logic [WIDTH-1:0]  gpio,
   output logic              ext_clk,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  txn_cnt
);

   localparam int MAX_LEN = (SETUP_CYC > HIGH_CYC)
                            ? ((SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC)
                            : ((HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC);
   localparam int PH_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_A,    // setup before edge=1 bits are driven
      ST_B,    // setup between edge=1 bits and ext_clk rise
      ST_C,    // ext_clk high, before edge=0 bits are driven
      ST_D,    // ext_clk high, edge=0 bits settling before fall
      ST_E     // ext_clk low tail
   } state_t;

   state_t              state_q, state_d;
   logic [PH_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]    gpio_q, gpio_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic [WIDTH-1:0]    use_ext_q, use_ext_d;
   logic [WIDTH-1:0]    edge_q, edge_d;
   logic                ext_clk_q, ext_clk_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    txn_cnt_q, txn_cnt_d;
   logic                accept;
   logic [WIDTH-1:0]    rise_mask;
   logic [WIDTH-1:0]    fall_mask;

   assign req_ready = (state_q == ST_IDLE) && !abort && rst_n;
   assign accept    = req_valid && req_ready;
   assign rise_mask = use_ext_q & edge_q;
   assign fall_mask = use_ext_q & ~edge_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gpio_d    = gpio_q;
      data_d    = data_q;
      use_ext_d = use_ext_q;
      edge_d    = edge_q;
      ext_clk_d = ext_clk_q;
      done_d    = 1'b0;
      txn_cnt_d = txn_cnt_q;

      if (state_q == ST_IDLE) begin
         if (accept) begin
            data_d    = req_data;
            use_ext_d = req_use_ext;
            edge_d    = req_edge;
            // Synchronous bits take the new value right at accept.
            gpio_d    = (gpio_q & req_use_ext) | (req_data & ~req_use_ext);
            state_d   = ST_A;
            cnt_d     = PH_W'(SETUP_CYC - 1);
         end
      end else if (abort) begin
         // Cancel: pins freeze where they are, clock forced low, no completion.
         state_d   = ST_IDLE;
         ext_clk_d = 1'b0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - PH_W'(1);
      end else begin
         case (state_q)
            ST_A: begin
               gpio_d  = (gpio_q & ~rise_mask) | (data_q & rise_mask);
               state_d = ST_B;
               cnt_d   = PH_W'(SETUP_CYC - 1);
            end
            ST_B: begin
               ext_clk_d = 1'b1;
               state_d   = ST_C;
               cnt_d     = PH_W'(HIGH_CYC - 1);
            end
            ST_C: begin
               gpio_d  = (gpio_q & ~fall_mask) | (data_q & fall_mask);
               state_d = ST_D;
               cnt_d   = PH_W'(HIGH_CYC - 1);
            end
            ST_D: begin
               ext_clk_d = 1'b0;
               state_d   = ST_E;
               cnt_d     = PH_W'(LOW_CYC - 1);
            end
            ST_E: begin
               done_d    = 1'b1;
               txn_cnt_d = txn_cnt_q + CNT_W'(1);
               state_d   = ST_IDLE;
            end
            default: begin
               state_d   = ST_IDLE;
               ext_clk_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         gpio_q    <= RESET_VAL;
         data_q    <= '0;
         use_ext_q <= '0;
         edge_q    <= '0;
         ext_clk_q <= 1'b0;
         done_q    <= 1'b0;
         txn_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gpio_q    <= gpio_d;
         data_q    <= data_d;
         use_ext_q <= use_ext_d;
         edge_q    <= edge_d;
         ext_clk_q <= ext_clk_d;
         done_q    <= done_d;
         txn_cnt_q <= txn_cnt_d;
      end
   end

   assign gpio    = gpio_q;
   assign ext_clk = ext_clk_q;
   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_gpio_ext_clk_driver.sv
// tb/tb_gpio_ext_clk_driver.sv - directed self-checking bench for gpio_ext_clk_driver
module tb_gpio_ext_clk_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_data;
   logic [31:0] req_use_ext;
   logic [31:0] req_edge;
   logic        abort;
   logic [31:0] gpio;
   logic        ext_clk;
   logic        busy;
   logic        done;
   logic [15:0] txn_cnt;

   logic        w_valid;
   logic        w_ready;
   logic [0:0]  w_data;
   logic [0:0]  w_use;
   logic [0:0]  w_edge;
   logic        w_abort;
   logic [0:0]  w_gpio;
   logic        w_ext_clk;
   logic        w_busy;
   logic        w_done;
   logic [1:0]  w_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   gpio_ext_clk_driver dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_use_ext(req_use_ext), .req_edge(req_edge),
      .abort(abort), .gpio(gpio), .ext_clk(ext_clk), .busy(busy), .done(done),
      .txn_cnt(txn_cnt)
   );

   gpio_ext_clk_driver #(
      .WIDTH(1), .SETUP_CYC(1), .HIGH_CYC(1), .LOW_CYC(1), .RESET_VAL(1'b0), .CNT_W(2)
   ) dut_w (
      .clk(clk), .rst_n(rst_n), .req_valid(w_valid), .req_ready(w_ready),
      .req_data(w_data), .req_use_ext(w_use), .req_edge(w_edge),
      .abort(w_abort), .gpio(w_gpio), .ext_clk(w_ext_clk), .busy(w_busy), .done(w_done),
      .txn_cnt(w_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int r1, r2, d1, d2;
      logic prev;
      logic saw_done;
      logic found;
      logic [31:0] exp_g;
      logic [1:0] wexp [5];
      wexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      rst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_use_ext = '0; req_edge = '0;
      abort = 1'b0; w_valid = 1'b0; w_data = '0; w_use = '0; w_edge = '0; w_abort = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_gpio", gpio, 32'h0);
      chk("rst_ext_clk", 32'(ext_clk), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready_low", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_ready_high", 32'(req_ready), 32'd1);

      // Sync-only transaction
      req_valid = 1'b1; req_data = 32'hA5A5_0F0F; req_use_ext = '0; req_edge = '0;
      tick();                       // T0
      req_valid = 1'b0;
      chk("sync_gpio_t0", gpio, 32'hA5A5_0F0F);
      chk("sync_busy", 32'(busy), 32'd1);
      chk("sync_ready_busy", 32'(req_ready), 32'd0);
      for (int k = 1; k <= 19; k++) begin
         tick();
         chk($sformatf("sync_ext_clk_k%0d", k), 32'(ext_clk), 32'((k >= 4) && (k < 14)));
         chk($sformatf("sync_done_k%0d", k), 32'(done), 32'(k == 19));
      end
      chk("sync_txn_cnt", 32'(txn_cnt), 32'd1);
      chk("sync_ready_at_done", 32'(req_ready), 32'd1);
      tick();
      chk("sync_done_one_cycle", 32'(done), 32'd0);

      // Mixed update timing, from gpio=0
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req_valid = 1'b1; req_data = 32'hDEAD_BEEF; req_use_ext = 32'hFFFF_0000; req_edge = 32'hFF00_0000;
      tick();                       // T0
      req_valid = 1'b0;
      chk("mix_gpio_k0", gpio, 32'h0000_BEEF);
      for (int k = 1; k <= 19; k++) begin
         tick();
         exp_g = 32'h0000_BEEF;
         if (k >= 2) exp_g = exp_g | 32'hDE00_0000;
         if (k >= 9) exp_g = exp_g | 32'h00AD_0000;
         chk($sformatf("mix_gpio_k%0d", k), gpio, exp_g);
         chk($sformatf("mix_ext_clk_k%0d", k), 32'(ext_clk), 32'((k >= 4) && (k < 14)));
      end
      chk("mix_done", 32'(done), 32'd1);

      // Back-to-back with request held
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req_valid = 1'b1; req_data = 32'h1234_5678; req_use_ext = '0; req_edge = '0;
      tick();                       // T0
      r1 = -1; r2 = -1; d1 = -1; d2 = -1; prev = ext_clk;
      for (int i = 1; i <= 45; i++) begin
         tick();
         if (ext_clk && !prev) begin
            if (r1 < 0) r1 = i;
            else if (r2 < 0) r2 = i;
         end
         prev = ext_clk;
         if (done) begin
            if (d1 < 0) begin
               d1 = i;
               chk("b2b_ready_at_done", 32'(req_ready), 32'd1);
            end else if (d2 < 0) begin
               d2 = i;
            end
         end
         if (i == 20) begin
            chk("b2b_second_accept_busy", 32'(busy), 32'd1);
            chk("b2b_second_accept_done_low", 32'(done), 32'd0);
            req_valid = 1'b0;
         end
      end
      chk("b2b_rise1", 32'(r1), 32'd4);
      chk("b2b_done1", 32'(d1), 32'd19);
      chk("b2b_rise2", 32'(r2), 32'd24);
      chk("b2b_rise_gap", 32'(r2 - r1), 32'd20);
      chk("b2b_done2", 32'(d2), 32'd39);
      chk("b2b_txn_cnt", 32'(txn_cnt), 32'd2);

      // Abort while ext_clk is high
      req_valid = 1'b1; req_data = 32'hFFFF_FFFF; req_use_ext = 32'h0000_FFFF; req_edge = 32'h0;
      tick();                       // T0
      req_valid = 1'b0;
      for (int k = 1; k <= 6; k++) tick();
      chk("abort_ext_before", 32'(ext_clk), 32'd1);
      abort = 1'b1;
      tick();                       // T0+7
      abort = 1'b0;
      chk("abort_ext_clk", 32'(ext_clk), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_gpio_hold", gpio, 32'hFFFF_5678);
      saw_done = done;
      for (int k = 0; k < 15; k++) begin
         tick();
         saw_done = saw_done | done;
      end
      chk("abort_no_done", 32'(saw_done), 32'd0);
      chk("abort_txn_cnt", 32'(txn_cnt), 32'd2);
      chk("abort_gpio_after", gpio, 32'hFFFF_5678);

      // Abort in IDLE blocks the accept
      req_valid = 1'b1; abort = 1'b1; req_use_ext = '0;
      #1;
      chk("abort_idle_ready", 32'(req_ready), 32'd0);
      tick();
      abort = 1'b0; req_valid = 1'b0;
      chk("abort_idle_no_accept", 32'(busy), 32'd0);
      chk("abort_idle_gpio", gpio, 32'hFFFF_5678);

      // Reset mid-transaction
      req_valid = 1'b1; req_data = 32'hCAFE_F00D; req_use_ext = '0;
      tick();                       // T0
      req_valid = 1'b0;
      for (int k = 1; k <= 9; k++) tick();
      rst_n = 1'b0;
      tick();                       // T0+10
      chk("midrst_gpio", gpio, 32'h0);
      chk("midrst_ext_clk", 32'(ext_clk), 32'd0);
      chk("midrst_txn_cnt", 32'(txn_cnt), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready_low", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("midrst_ready_high", 32'(req_ready), 32'd1);

      // Counter wrap on the 1-bit, 2-bit-counter instance
      w_valid = 1'b1; w_data = 1'b1; w_use = 1'b1; w_edge = 1'b1;
      for (int n = 0; n < 5; n++) begin
         found = 1'b0;
         for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (w_done) found = 1'b1;
         end
         chk($sformatf("wrap_done_seen_%0d", n), 32'(found), 32'd1);
         chk($sformatf("wrap_cnt_%0d", n), 32'(w_cnt), 32'(wexp[n]));
      end
      w_valid = 1'b0;
      chk("wrap_gpio_w1", 32'(w_gpio), 32'd1);
      chk("wrap_ext_low", 32'(w_ext_clk), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
